// File: rtl/gray_decoder.sv
// Gray-to-binary decoder with step classification and lock tracking; 2-cycle latency.
// No backpressure: every in_valid sample is accepted; idle cycles become output bubbles.
module gray_decoder #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic [1:0]       dir,
  output logic             step_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACQ  = 2'b01,
    ST_LOCK = 2'b10
  } state_t;

  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;
  localparam logic [1:0] DIR_ILL  = 2'b11;

  logic             r_s1_vld;
  logic [WIDTH-1:0] r_s1_gray;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_bin;
  logic [1:0]       r_dir;
  logic             r_step_err;
  logic [WIDTH-1:0] r_prev;
  logic [ERR_W-1:0] r_err_cnt;
  state_t           r_state;

  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_diff;
  logic [1:0]       w_cls;
  logic [1:0]       w_dir;
  logic             w_err;
  state_t           w_state_nxt;

  // Each binary bit is the XOR of the gray bits at and above it.
  always_comb begin
    w_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_bin[i] = ^(r_s1_gray >> i);
    end
  end

  // Modulo-2^WIDTH difference makes the wrap steps fall out as ordinary +1/-1.
  always_comb begin
    w_diff = w_bin - r_prev;
    if (w_diff == '0) begin
      w_cls = DIR_HOLD;
    end else if (w_diff == WIDTH'(1)) begin
      w_cls = DIR_UP;
    end else if (w_diff == '1) begin
      w_cls = DIR_DN;
    end else begin
      w_cls = DIR_ILL;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dir       = DIR_HOLD;
    w_err       = 1'b0;
    if (r_s1_vld) begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ACQ;
        end
        ST_ACQ: begin
          w_dir = w_cls;
          w_err = (w_cls == DIR_ILL);
          if (w_cls == DIR_UP || w_cls == DIR_DN) begin
            w_state_nxt = ST_LOCK;
          end
        end
        ST_LOCK: begin
          w_dir = w_cls;
          w_err = (w_cls == DIR_ILL);
          if (w_cls == DIR_ILL) begin
            w_state_nxt = ST_ACQ;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_gray <= '0;
    end else begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_gray <= gray_in;
      end
    end
  end

  // bin_out and dir keep their last value across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_bin       <= '0;
      r_dir       <= DIR_HOLD;
      r_step_err  <= 1'b0;
      r_prev      <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_out_valid <= r_s1_vld;
      r_step_err  <= w_err;
      if (r_s1_vld) begin
        r_bin  <= w_bin;
        r_dir  <= w_dir;
        r_prev <= w_bin;
      end
      if (w_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign bin_out   = r_bin;
  assign dir       = r_dir;
  assign step_err  = r_step_err;
  assign locked    = (r_state == ST_LOCK);
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_gray_decoder.sv
// Scoreboard bench for gray_decoder: a reference model predicts each output at drive time.
module tb_gray_decoder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] gray_in;
  logic       out_valid;
  logic [3:0] bin_out;
  logic [1:0] dir;
  logic       step_err;
  logic       locked;
  logic [7:0] err_cnt;

  gray_decoder #(.WIDTH(4), .ERR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .gray_in   (gray_in),
    .out_valid (out_valid),
    .bin_out   (bin_out),
    .dir       (dir),
    .step_err  (step_err),
    .locked    (locked),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    logic [3:0] bin;
    logic [1:0] dir;
    logic       err;
    logic       lck;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state: 0 idle, 1 acquiring, 2 locked.
  int         m_state = 0;
  logic [3:0] m_prev  = 4'd0;
  logic [7:0] m_cnt   = 8'd0;
  logic [3:0] last_bin = 4'd0;
  logic [1:0] last_dir = 2'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    q.delete();
    m_state = 0;
    m_prev  = 4'd0;
    m_cnt   = 8'd0;
  endtask

  task automatic push(input logic [3:0] b);
    exp_t e;
    logic [3:0] d;
    e.bin = b;
    e.dir = 2'b00;
    e.err = 1'b0;
    if (m_state == 0) begin
      m_state = 1;
    end else begin
      d = b - m_prev;
      if (d == 4'd0)       e.dir = 2'b00;
      else if (d == 4'd1)  e.dir = 2'b01;
      else if (d == 4'd15) e.dir = 2'b10;
      else                 e.dir = 2'b11;
      e.err = (e.dir == 2'b11);
      if (e.err)                m_state = 1;
      else if (e.dir != 2'b00)  m_state = 2;
    end
    m_prev = b;
    if (e.err && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    e.lck = (m_state == 2);
    e.cnt = m_cnt;
    e.cyc = cyc + 2;
    q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [3:0] b);
    in_valid = v;
    gray_in  = b2g(b);
    if (v) push(b);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (q.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #1;
    chk("drain", q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_bin = 4'd0;
      last_dir = 2'd0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexp_vld", 1, 0);
      end else begin
        e = q.pop_front();
        chk("latency", cyc, e.cyc);
        chk("bin", bin_out, e.bin);
        chk("dir", dir, e.dir);
        chk("step_err", step_err, e.err);
        chk("locked", locked, e.lck);
        chk("err_cnt", err_cnt, e.cnt);
        last_bin = e.bin;
        last_dir = e.dir;
      end
    end else begin
      chk("hold_bin", bin_out, last_bin);
      chk("hold_dir", dir, last_dir);
      chk("err_no_vld", step_err, 0);
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    gray_in  = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", out_valid, 0);
    chk("rst_bin", bin_out, 0);
    chk("rst_dir", dir, 0);
    chk("rst_err", step_err, 0);
    chk("rst_lck", locked, 0);
    chk("rst_cnt", err_cnt, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Up-count through the full range and wrap back to zero.
    for (int i = 0; i < 16; i++) drive(1'b1, 4'(i));
    drive(1'b1, 4'd0);
    drain();
    chk("up_cnt", err_cnt, 0);

    // Down-count including the 0 -> 15 wrap.
    drive(1'b1, 4'd15);
    for (int i = 14; i >= 0; i--) drive(1'b1, 4'(i));
    drive(1'b1, 4'd15);
    drain();
    chk("dn_cnt", err_cnt, 0);

    // Illegal jump out of lock, then relock.
    drive(1'b1, 4'd0);
    drive(1'b1, 4'd1);
    drive(1'b1, 4'd2);
    drive(1'b1, 4'd4);
    drive(1'b1, 4'd5);
    drain();
    chk("jump_cnt", err_cnt, 1);

    // Bubbles between two identical samples.
    drive(1'b1, 4'd6);
    drive(1'b0, 4'd6);
    drive(1'b0, 4'd6);
    drive(1'b1, 4'd6);
    drain();

    // Counter saturation.
    for (int i = 0; i < 300; i++) drive(1'b1, (i % 2 == 0) ? 4'd0 : 4'd8);
    drain();
    chk("sat_cnt", err_cnt, 255);

    // Mid-stream reset with samples in flight.
    drive(1'b1, 4'd3);
    rst      = 1'b1;
    in_valid = 1'b1;
    gray_in  = b2g(4'd9);
    #1;
    chk("mid_vld", out_valid, 0);
    chk("mid_bin", bin_out, 0);
    chk("mid_dir", dir, 0);
    chk("mid_lck", locked, 0);
    chk("mid_cnt", err_cnt, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    drive(1'b1, 4'd7);
    drive(1'b1, 4'd8);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
